interrupt_request_ctrl: RTL and testbench
=========================================

# interrupt_request_ctrl

Upstream interrupt front end for the pipelined RISC-V CPU. Conditions asynchronous board inputs (buttons, external lines) into the CPU's `IRQ` bus:
- synchronises and debounces each input;
- latches rising edges as pending requests;
- presents the highest-priority unmasked request one-hot;
- retires a request when the CPU raises the matching `IRW` (in-service) bit.

## Interface
Parameters:
- `N_SRC`, 3, number of interrupt sources; index N_SRC-1 is highest priority.
- `DEBOUNCE_CYCLES`, 8, consecutive stable cycles required before the debounced level changes (≥2).
- `DROP_W`, 8, width of the dropped-request counter.

Ports:
- `clk`  in  1  system clock; all state on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `src_in`  in  N_SRC  raw asynchronous request lines, active-high.
- `irq_mask`  in  N_SRC  synchronous; 1 = source suppressed from `IRQ`; still latched as pending.
- `IRW`  in  N_SRC  synchronous in-service bits from the CPU.
- `IRQ`  out  N_SRC  registered, one-hot or zero, request to the CPU.
- `pending`  out  N_SRC  registered pending-request flags.
- `dropped_cnt`  out  DROP_W  saturating count of edges lost because the source was already pending.

## Operation
Per source i:
- **Sync:** 2-flop synchroniser `s1[i]`→`s2[i]`.
- **Debounce** (when `DEBOUNCE_EN`): counter `cnt[i]` and level `deb[i]`.
  - If `s2[i]==deb[i]`: `cnt` ← 0.
  - Else if `cnt==DEBOUNCE_CYCLES-1`: `deb` ← `s2`, `cnt` ← 0.
  - Else: `cnt` ← `cnt+1`.
  - Glitches shorter than DEBOUNCE_CYCLES never change `deb`.
- **Edge detect:** `deb_q[i]` ← `deb[i]`. `rise[i] = deb[i] & ~deb_q[i]`. Falling edges are ignored.
- **Ack detect:** `IRW_q[i]` ← `IRW[i]`. `ack[i] = IRW[i] & ~IRW_q[i]`. A held-high `IRW` acknowledges once only.
- **Pending update:**
  - `pending[i]` ← `rise[i] | (pending[i] & ~ack[i])`.
  - If `rise` and `ack` occur in the same cycle, `rise` wins and pending stays 1. This is a new request, not a drop.
- **Drop:** `rise[i] & pending[i] & ~ack[i]` counts as a drop.
  - `dropped_cnt` increments by the number of sources dropping in that cycle (0..N_SRC).
  - It saturates at 2^DROP_W−1 and never wraps.
- **Arbitration:**
  - `IRQ` ← one-hot of the highest index set in `pending & ~irq_mask`, computed from the current (pre-update) `pending`.
  - If none is set, `IRQ` ← 0.
  - `IRQ` never has more than one bit set.
- **Masking:**
  - A masked pending request stays pending.
  - It appears on `IRQ` the cycle after its mask bit clears, if it is still the highest priority.
- **Preemption:** a newly pending higher-priority request replaces the current `IRQ` bit. The lower request stays pending.

## Timing
- **Reset** (`rst`=0, asynchronous): all of the following clear to 0 immediately:
  - `IRQ`, `pending`, `dropped_cnt`;
  - `s1`, `s2`, `cnt`, `deb`, `deb_q`, `IRW_q`.
- Deassertion of `rst` is synchronous to the design; the first state update occurs on the first `clk` rising edge with `rst`=1.
- Reset mid-debounce or mid-request discards all pending and in-progress state. A source held high across reset produces a fresh rise D+2 edges after release. D = DEBOUNCE_CYCLES.
- **Latency from `src_in` rising** before edge 0, with `DEBOUNCE_EN`:
  - `s2` = 1 after edge 1.
  - `deb` = 1 after edge 1+D.
  - `pending` = 1 after edge 2+D.
  - `IRQ` = 1 after edge 3+D. For D=8, `IRQ` is high after edge 11.
- **Ack latency:** `IRW[i]` rising sampled at edge k clears `pending[i]` at edge k. `IRQ[i]` drops at edge k+1.
- No combinational path from any input to any output.

## Configuration
- `IRQ_DEBOUNCE_EN` defined: debounce filter compiled in as above.
- `IRQ_DEBOUNCE_EN` undefined:
  - the `cnt` and `deb` registers are not built;
  - `deb[i]` = `s2[i]`, `DEBOUNCE_CYCLES` is ignored;
  - `src_in` rising before edge 0 gives `pending` after edge 2 and `IRQ` after edge 3;
  - single-cycle glitches that survive the synchroniser register as requests.

## Test plan
- **Reset/basic:**
  - Stimulus: `rst` low mid-cycle.
  - Response: all outputs 0 without a clock.
  - Then release `rst`, drive `src_in`=3'b010 before edge 0 (D=8), hold 20 cycles.
  - Response: `pending`=3'b010 after edge 10, `IRQ`=3'b010 after edge 11, `dropped_cnt`=0.
- **Glitch rejection** (`IRQ_DEBOUNCE_EN`):
  - Stimulus: 5-cycle pulse on `src_in[0]`.
  - Response: `pending` and `IRQ` stay 0. A 12-cycle pulse sets `pending[0]`.
- **Priority and ack:**
  - Stimulus: `pending`=3'b101. Response: `IRQ`=3'b100.
  - Stimulus: raise `IRW[2]` at edge k. Response: `pending`=3'b001 at k, `IRQ`=3'b001 at k+1.
  - Stimulus: hold `IRW[2]` high 10 cycles. Response: no further clears.
- **Mask:**
  - Stimulus: `irq_mask`=3'b100 with `pending`=3'b110. Response: `IRQ`=3'b010.
  - Stimulus: clear mask at edge j. Response: `IRQ`=3'b100 after edge j+1.
- **Drop/simultaneous:**
  - Stimulus: second debounced rise on source 1 while pending. Response: `dropped_cnt` 0→1.
  - Stimulus: rise coincident with `IRW[1]` rising. Response: `pending[1]` stays 1, count unchanged.
  - Stimulus: force 300 drops. Response: `dropped_cnt` holds 255.
- **Reset mid-operation:**
  - Stimulus: assert `rst` with `pending`=3'b011 and a debounce half-counted.
  - Response: all cleared. With the source held high, a new rise reaches `pending` after edge D+2 post-release.

Source files
------------

// File: rtl/interrupt_request_ctrl.sv
// Interrupt front end: synchronise, optionally debounce (IRQ_DEBOUNCE_EN), latch rising
// edges as pending requests, and present the highest-priority unmasked one on IRQ.
module interrupt_request_ctrl #(
  parameter int N_SRC           = 3,
  parameter int DEBOUNCE_CYCLES = 8,
  parameter int DROP_W          = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_SRC-1:0]  src_in,
  input  logic [N_SRC-1:0]  irq_mask,
  input  logic [N_SRC-1:0]  IRW,
  output logic [N_SRC-1:0]  IRQ,
  output logic [N_SRC-1:0]  pending,
  output logic [DROP_W-1:0] dropped_cnt
);

  localparam int NCW = $clog2(N_SRC + 1);

  if (DEBOUNCE_CYCLES < 2) begin : g_cfg_check
    $error("DEBOUNCE_CYCLES must be at least 2");
  end

  logic [N_SRC-1:0]  s1_q, s1_d, s2_q, s2_d;
  logic [N_SRC-1:0]  deb_prev_q, deb_prev_d;
  logic [N_SRC-1:0]  irw_prev_q, irw_prev_d;
  logic [N_SRC-1:0]  pending_q, pending_d;
  logic [N_SRC-1:0]  irq_q, irq_d;
  logic [DROP_W-1:0] dropped_q, dropped_d;

  logic [N_SRC-1:0]  deb, rise, ack, drop_hit, cand;
  logic [NCW-1:0]    drop_n;
  logic [DROP_W:0]   drop_sum;

`ifdef IRQ_DEBOUNCE_EN
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);

  logic [N_SRC-1:0] deb_q, deb_d;
  logic [CNT_W-1:0] cnt_q [N_SRC];
  logic [CNT_W-1:0] cnt_d [N_SRC];

  // The level only follows s2 after it has differed for DEBOUNCE_CYCLES edges in a row.
  always_comb begin
    deb_d = deb_q;
    for (int i = 0; i < N_SRC; i++) begin
      cnt_d[i] = '0;
      if (s2_q[i] != deb_q[i]) begin
        if (cnt_q[i] == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
          deb_d[i] = s2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      deb_q <= '0;
      for (int i = 0; i < N_SRC; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      deb_q <= deb_d;
      cnt_q <= cnt_d;
    end
  end

  assign deb = deb_q;
`else
  assign deb = s2_q;
`endif

  always_comb begin
    s1_d       = src_in;
    s2_d       = s1_q;
    deb_prev_d = deb;
    irw_prev_d = IRW;

    rise      = deb & ~deb_prev_q;
    ack       = IRW & ~irw_prev_q;
    drop_hit  = rise & pending_q & ~ack;
    pending_d = rise | (pending_q & ~ack);

    // Arbitration looks at pending before this cycle's update; highest index wins.
    cand  = pending_q & ~irq_mask;
    irq_d = '0;
    for (int i = 0; i < N_SRC; i++) begin
      if (cand[i]) begin
        irq_d = N_SRC'(1) << i;
      end
    end

    drop_n = '0;
    for (int i = 0; i < N_SRC; i++) begin
      drop_n = drop_n + NCW'(drop_hit[i]);
    end
    drop_sum  = {1'b0, dropped_q} + (DROP_W + 1)'(drop_n);
    dropped_d = drop_sum[DROP_W] ? '1 : drop_sum[DROP_W-1:0];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_q       <= '0;
      s2_q       <= '0;
      deb_prev_q <= '0;
      irw_prev_q <= '0;
      pending_q  <= '0;
      irq_q      <= '0;
      dropped_q  <= '0;
    end else begin
      s1_q       <= s1_d;
      s2_q       <= s2_d;
      deb_prev_q <= deb_prev_d;
      irw_prev_q <= irw_prev_d;
      pending_q  <= pending_d;
      irq_q      <= irq_d;
      dropped_q  <= dropped_d;
    end
  end

  assign IRQ         = irq_q;
  assign pending     = pending_q;
  assign dropped_cnt = dropped_q;

endmodule

// File: tb/tb_interrupt_request_ctrl.sv
// Self-checking bench for interrupt_request_ctrl: directed vector table, hand-written
// corner sequences, then random stimulus against a history-window reference model.
module tb_interrupt_request_ctrl;

  localparam int N  = 3;
  localparam int D  = 8;
  localparam int DW = 8;
`ifdef IRQ_DEBOUNCE_EN
  localparam int PLAT = D + 2;
`else
  localparam int PLAT = 2;
`endif
  localparam int HOLD = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [N-1:0]  src = '0;
  logic [N-1:0]  mask = '0;
  logic [N-1:0]  irw = '0;
  logic [N-1:0]  irq_o, pend_o;
  logic [DW-1:0] drop_o;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  interrupt_request_ctrl #(
    .N_SRC(N),
    .DEBOUNCE_CYCLES(D),
    .DROP_W(DW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .src_in(src),
    .irq_mask(mask),
    .IRW(irw),
    .IRQ(irq_o),
    .pending(pend_o),
    .dropped_cnt(drop_o)
  );

  // Reference model: the synchroniser is a sample history, the debounced level flips
  // once the last D synchronised samples all agree on the opposite value.
  logic [31:0]  m_hist [N];
  logic [N-1:0] m_pend, m_irq, m_irw_prev, m_rise, m_ack;
  logic         m_found;
  int           m_drop;
`ifdef IRQ_DEBOUNCE_EN
  logic [N-1:0] m_deb, m_debq;
  logic [D-1:0] m_win;
`endif

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < N; i++) m_hist[i] = '0;
      m_pend = '0; m_irq = '0; m_irw_prev = '0; m_drop = 0;
`ifdef IRQ_DEBOUNCE_EN
      m_deb = '0; m_debq = '0;
`endif
    end else begin
      for (int i = 0; i < N; i++) begin
`ifdef IRQ_DEBOUNCE_EN
        m_rise[i] = m_deb[i] & ~m_debq[i];
`else
        m_rise[i] = m_hist[i][1] & ~m_hist[i][2];
`endif
        m_ack[i] = irw[i] & ~m_irw_prev[i];
      end
      m_irq = '0;
      m_found = 1'b0;
      for (int i = N - 1; i >= 0; i--) begin
        if (!m_found && m_pend[i] && !mask[i]) begin
          m_irq[i] = 1'b1;
          m_found = 1'b1;
        end
      end
      for (int i = 0; i < N; i++) begin
        if (m_rise[i] && m_pend[i] && !m_ack[i]) m_drop++;
      end
      if (m_drop > (1 << DW) - 1) m_drop = (1 << DW) - 1;
      m_pend = m_rise | (m_pend & ~m_ack);
`ifdef IRQ_DEBOUNCE_EN
      m_debq = m_deb;
      for (int i = 0; i < N; i++) begin
        m_win = m_hist[i][D:1];
        if (&m_win && !m_deb[i]) m_deb[i] = 1'b1;
        else if (m_win == '0 && m_deb[i]) m_deb[i] = 1'b0;
      end
`endif
      m_irw_prev = irw;
      for (int i = 0; i < N; i++) m_hist[i] = {m_hist[i][30:0], src[i]};
    end
  end

  typedef struct {
    logic [N-1:0] src, mask, irw;
    logic [N-1:0] exp_pend, exp_irq;
    int           exp_drop;
  } vec_t;

  vec_t vecs [12];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [N-1:0] s, input logic [N-1:0] m, input logic [N-1:0] w);
    src  = s;
    mask = m;
    irw  = w;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    // Each row holds long enough for any debounce latency to have settled.
    vecs[0]  = '{3'b010, 3'b000, 3'b000, 3'b010, 3'b010, 0};
    vecs[1]  = '{3'b111, 3'b000, 3'b000, 3'b111, 3'b100, 0};
    vecs[2]  = '{3'b111, 3'b000, 3'b100, 3'b011, 3'b010, 0};
    vecs[3]  = '{3'b111, 3'b010, 3'b100, 3'b011, 3'b001, 0};
    vecs[4]  = '{3'b111, 3'b000, 3'b000, 3'b011, 3'b010, 0};
    vecs[5]  = '{3'b000, 3'b000, 3'b000, 3'b011, 3'b010, 0};
    vecs[6]  = '{3'b010, 3'b000, 3'b000, 3'b011, 3'b010, 1};
    vecs[7]  = '{3'b010, 3'b000, 3'b010, 3'b001, 3'b001, 1};
    vecs[8]  = '{3'b010, 3'b000, 3'b011, 3'b000, 3'b000, 1};
    vecs[9]  = '{3'b101, 3'b000, 3'b000, 3'b101, 3'b100, 1};
    vecs[10] = '{3'b101, 3'b111, 3'b000, 3'b101, 3'b000, 1};
    vecs[11] = '{3'b101, 3'b011, 3'b000, 3'b101, 3'b100, 1};

    repeat (3) tick();
    checkOutput("reset_irq", irq_o, 0);
    checkOutput("reset_pend", pend_o, 0);
    checkOutput("reset_drop", drop_o, 0);

    // Release with source 1 already high before edge 0.
    rst = 1'b1;
    applyStimulus(3'b010, 3'b000, 3'b000);
    for (int k = 0; k <= PLAT + 1; k++) begin
      tick();
      if (k == PLAT - 1) checkOutput("lat_pend_early", pend_o, 0);
      if (k == PLAT) begin
        checkOutput("lat_pend", pend_o, 3'b010);
        checkOutput("lat_irq_early", irq_o, 0);
      end
      if (k == PLAT + 1) begin
        checkOutput("lat_irq", irq_o, 3'b010);
        checkOutput("lat_drop", drop_o, 0);
      end
    end

    for (int v = 0; v < 12; v++) begin
      applyStimulus(vecs[v].src, vecs[v].mask, vecs[v].irw);
      repeat (HOLD) tick();
      checkOutput($sformatf("vec%0d_pend", v), pend_o, vecs[v].exp_pend);
      checkOutput($sformatf("vec%0d_irq", v), irq_o, vecs[v].exp_irq);
      checkOutput($sformatf("vec%0d_drop", v), drop_o, vecs[v].exp_drop);
    end

    // Asynchronous reset mid-cycle, no clock edge in between.
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("async_rst_irq", irq_o, 0);
    checkOutput("async_rst_pend", pend_o, 0);
    checkOutput("async_rst_drop", drop_o, 0);
    applyStimulus(3'b000, 3'b000, 3'b000);
    repeat (2) tick();
    rst = 1'b1;
    repeat (3) tick();

`ifdef IRQ_DEBOUNCE_EN
    applyStimulus(3'b001, 3'b000, 3'b000);
    repeat (5) tick();
    applyStimulus(3'b000, 3'b000, 3'b000);
    repeat (20) tick();
    checkOutput("glitch5_pend", pend_o, 0);
    checkOutput("glitch5_irq", irq_o, 0);
    applyStimulus(3'b001, 3'b000, 3'b000);
    repeat (12) tick();
    applyStimulus(3'b000, 3'b000, 3'b000);
    repeat (20) tick();
    checkOutput("pulse12_pend", pend_o, 3'b001);
`else
    applyStimulus(3'b001, 3'b000, 3'b000);
    tick();
    applyStimulus(3'b000, 3'b000, 3'b000);
    repeat (10) tick();
    checkOutput("glitch1_pend", pend_o, 3'b001);
`endif
    checkOutput("pulse_irq", irq_o, 3'b001);

    // Rise on source 1 landing on the same edge as IRW[1] rising.
    applyStimulus(3'b010, 3'b000, 3'b000);
    repeat (HOLD) tick();
    checkOutput("pre_sim_pend", pend_o, 3'b011);
    applyStimulus(3'b000, 3'b000, 3'b000);
    repeat (HOLD) tick();
    applyStimulus(3'b010, 3'b000, 3'b000);
    repeat (PLAT) tick();
    applyStimulus(3'b010, 3'b000, 3'b010);
    tick();
    checkOutput("sim_pend", pend_o, 3'b011);
    checkOutput("sim_drop", drop_o, 0);
    repeat (10) tick();
    checkOutput("irw_held_pend", pend_o, 3'b011);
    checkOutput("irw_held_irq", irq_o, 3'b010);

    // Saturation: all three sources toggle together while pending is never acked.
    applyStimulus(3'b000, 3'b000, 3'b000);
    repeat (HOLD) tick();
    for (int it = 0; it < 100; it++) begin
      applyStimulus(3'b111, 3'b000, 3'b000);
      repeat (PLAT + 2) tick();
      if (it == 0) checkOutput("drop_first", drop_o, 2);
      applyStimulus(3'b000, 3'b000, 3'b000);
      repeat (PLAT + 2) tick();
    end
    checkOutput("drop_sat", drop_o, 255);
    checkOutput("drop_sat_pend", pend_o, 3'b111);
    checkOutput("drop_sat_irq", irq_o, 3'b100);

    // Reset with requests pending and a debounce in progress.
    applyStimulus(3'b000, 3'b000, 3'b100);
    tick();
    applyStimulus(3'b000, 3'b000, 3'b000);
    tick();
    checkOutput("pre_rst_pend", pend_o, 3'b011);
    applyStimulus(3'b100, 3'b000, 3'b000);
    repeat (4) tick();
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("midrst_pend", pend_o, 0);
    checkOutput("midrst_irq", irq_o, 0);
    checkOutput("midrst_drop", drop_o, 0);
    repeat (2) tick();
    rst = 1'b1;
    for (int k = 0; k <= PLAT; k++) begin
      tick();
      if (k == PLAT - 1) checkOutput("postrst_pend_early", pend_o, 0);
      if (k == PLAT) checkOutput("postrst_pend", pend_o, 3'b100);
    end

    // Random stimulus against the reference model.
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(3'b000, 3'b000, 3'b000);
    repeat (2) tick();
    rst = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 9) == 0) src = N'($urandom);
      if ($urandom_range(0, 15) == 0) mask = N'($urandom);
      if ($urandom_range(0, 3) == 0) irw = N'($urandom);
      tick();
      checkOutput($sformatf("rnd%0d_pend", c), pend_o, m_pend);
      checkOutput($sformatf("rnd%0d_irq", c), irq_o, m_irq);
      checkOutput($sformatf("rnd%0d_drop", c), drop_o, m_drop);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
